shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 85 ++++++++
 tb/tb_shift_add_multiplier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned NxN radix-2 shift-and-add multiplier.
// Ports: clock, reset (async, active-high), start, multiplicand, multiplier
//        -> product (2N, running partial), ready (result valid).
module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           ready
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ready_q, ready_d;
  logic [N:0]     sum;

  // Upper half plus gated multiplicand, with the carry bit kept.
  assign sum = {1'b0, prod_q[2*N-1:N]}
             + (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prod_q  <= '0;
      mcand_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    count_d = count_q;
    ready_d = ready_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          prod_d  = {{N{1'b0}}, multiplier};
          mcand_d = multiplicand;
          count_d = '0;
          ready_d = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Shift right by one; the carry enters the MSB.
        prod_d  = {sum, prod_q[N-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          state_d = DONE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign product = prod_q;
  assign ready   = ready_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier.
// Directed and random operations against an arithmetic reference.
module tb_shift_add_multiplier;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           ready;

  int n_checks = 0;
  int n_fail   = 0;

  shift_add_multiplier #(.N(N)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .ready        (ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // After i of N steps the low i multiplier bits have been consumed:
  // upper part is a*(b mod 2^i) aligned at bit N-i, lower is b >> i.
  function automatic int partial(input int a, input int b, input int i);
    int lo;
    lo = b % (1 << i);
    return ((a * lo) << (N - i)) | (b >> i);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Load a*b, then run N steps. If poke is 1..N, start is raised with
  // other operands on the edge of that step; it must be ignored.
  task automatic run_op(input int a, input int b, input int poke);
    multiplicand = N'(a);
    multiplier   = N'(b);
    start        = 1'b1;
    tick();
    start = 1'b0;
    multiplicand = N'($urandom);
    multiplier   = N'($urandom);
    check("load_prod", product, b);
    check("load_rdy", ready, 0);
    for (int i = 1; i <= N; i++) begin
      start = (i == poke);
      if (i == poke) begin
        multiplicand = N'(a + 1);
        multiplier   = N'(b + 3);
      end
      tick();
      start = 1'b0;
      check($sformatf("step%0d_prod", i), product, partial(a, b, i));
      check($sformatf("step%0d_rdy", i), ready, (i == N) ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #1;
    check("rst_prod", product, 0);
    check("rst_rdy", ready, 0);
    #12;
    reset = 1'b0;
    tick();
    check("idle_prod", product, 0);
    check("idle_rdy", ready, 0);

    run_op(11, 6, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_prod", product, 66);
      check("hold_rdy", ready, 1);
    end

    run_op(15, 15, 0);
    check("sq_max", product, 225);
    run_op(0, 13, 0);
    check("zero_a", product, 0);
    run_op(13, 0, 0);
    check("zero_b", product, 0);

    run_op(11, 6, 3);
    check("poke_res", product, 66);

    // Abort after step 2 with an asynchronous reset.
    multiplicand = 4'd11;
    multiplier   = 4'd6;
    start        = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("abort_prod", product, 0);
    check("abort_rdy", ready, 0);
    #1;
    reset = 1'b0;
    run_op(5, 9, 0);
    check("after_abort", product, 45);

    // Back-to-back: ready must drop on the reload edge.
    run_op(7, 9, 0);
    check("b2b_res", product, 63);

    // Start held across completion: ready high exactly one cycle.
    multiplicand = 4'd3;
    multiplier   = 4'd5;
    start        = 1'b1;
    tick();
    multiplicand = 4'd12;
    multiplier   = 4'd10;
    for (int i = 1; i <= N; i++) tick();
    check("held_prod", product, 15);
    check("held_rdy", ready, 1);
    tick();
    start = 1'b0;
    check("reload_prod", product, 10);
    check("reload_rdy", ready, 0);
    for (int i = 1; i <= N; i++) tick();
    check("held2_prod", product, 120);
    check("held2_rdy", ready, 1);

    for (int t = 0; t < 40; t++) begin
      int a, b;
      a = int'($urandom_range((1 << N) - 1, 0));
      b = int'($urandom_range((1 << N) - 1, 0));
      run_op(a, b, (t % 5 == 0) ? int'($urandom_range(N, 1)) : 0);
      check("rand_res", product, a * b);
      if (t % 3 == 0) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
